conv_line_buffer: RTL and testbench

//   Three-row line buffer directly upstream of the convolve stage. Accepts a raster pixel

---
 rtl/conv_line_buffer.sv | 165 ++++++++++++++++
 tb/tb_conv_line_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - three-row rotating line buffer feeding the convolve stage
// Presents one vertically aligned column per shift_buffer pulse and slides down one row per band.
module conv_line_buffer #(
  parameter int BIT_DEPTH = 8,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BIT_DEPTH-1:0]     pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic                     shift_buffer,
  output logic [BIT_DEPTH-1:0]     in_l1,
  output logic [BIT_DEPTH-1:0]     in_l2,
  output logic [BIT_DEPTH-1:0]     in_l3,
  output logic                     lines_valid,
  output logic [$clog2(IMG_W)-1:0] col_idx,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int BW = $clog2(IMG_H);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_SERVE, S_REFILL, S_DONE} state_t;

  state_t               state_q;
  logic [BIT_DEPTH-1:0] bank_q [3][IMG_W];
  logic [CW-1:0]        wr_col_q, col_q, col_d;
  logic [1:0]           row_cnt_q, top_q, top1, top2, wr_bank;
  logic [BW-1:0]        band_q;
  logic [BIT_DEPTH-1:0] l1_q, l2_q, l3_q;
  logic                 pix_ready_q, lines_valid_q, busy_q, frame_done_q;
  logic                 accept, last_col_wr;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  always_comb begin
    accept      = pix_valid & pix_ready_q;
    last_col_wr = (wr_col_q == CW'(IMG_W - 1));
    wr_bank     = (state_q == S_FILL) ? row_cnt_q : top_q;
    col_d       = col_q + CW'(1);
    top1        = inc3(top_q);
    top2        = inc3(top1);
  end

  // Bank storage carries no reset; contents are only read after being written this frame.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      bank_q[wr_bank][wr_col_q] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_col_q      <= '0;
      row_cnt_q     <= '0;
      band_q        <= '0;
      top_q         <= '0;
      col_q         <= '0;
      l1_q          <= '0;
      l2_q          <= '0;
      l3_q          <= '0;
      pix_ready_q   <= 1'b0;
      lines_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_FILL;
            pix_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            wr_col_q    <= '0;
            row_cnt_q   <= '0;
            band_q      <= '0;
            top_q       <= '0;
          end
        end
        S_FILL: begin
          if (accept) begin
            if (last_col_wr) begin
              wr_col_q <= '0;
              if (row_cnt_q == 2'd2) begin
                // Column 0 of every row is already stored, so it can be presented right away.
                state_q       <= S_SERVE;
                pix_ready_q   <= 1'b0;
                lines_valid_q <= 1'b1;
                col_q         <= '0;
                l1_q          <= bank_q[top_q][0];
                l2_q          <= bank_q[top1][0];
                l3_q          <= bank_q[top2][0];
              end else begin
                row_cnt_q <= row_cnt_q + 2'd1;
              end
            end else begin
              wr_col_q <= wr_col_q + CW'(1);
            end
          end
        end
        S_SERVE: begin
          if (shift_buffer && lines_valid_q) begin
            if (col_q != CW'(IMG_W - 1)) begin
              col_q <= col_d;
              l1_q  <= bank_q[top_q][col_d];
              l2_q  <= bank_q[top1][col_d];
              l3_q  <= bank_q[top2][col_d];
            end else begin
              lines_valid_q <= 1'b0;
              if (band_q != BW'(IMG_H - 3)) begin
                band_q      <= band_q + BW'(1);
                state_q     <= S_REFILL;
                pix_ready_q <= 1'b1;
                wr_col_q    <= '0;
              end else begin
                state_q      <= S_DONE;
                frame_done_q <= 1'b1;
              end
            end
          end
        end
        S_REFILL: begin
          if (accept) begin
            if (last_col_wr) begin
              // The refilled (oldest) bank becomes the bottom row; the window rotates down.
              wr_col_q      <= '0;
              state_q       <= S_SERVE;
              pix_ready_q   <= 1'b0;
              lines_valid_q <= 1'b1;
              col_q         <= '0;
              top_q         <= top1;
              l1_q          <= bank_q[top1][0];
              l2_q          <= bank_q[top2][0];
              l3_q          <= bank_q[top_q][0];
            end else begin
              wr_col_q <= wr_col_q + CW'(1);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pix_ready   = pix_ready_q;
  assign in_l1       = l1_q;
  assign in_l2       = l2_q;
  assign in_l3       = l3_q;
  assign lines_valid = lines_valid_q;
  assign col_idx     = col_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_conv_line_buffer.sv
// tb/tb_conv_line_buffer.sv - scoreboard bench for conv_line_buffer (4x5 frame, 8-bit pixels)
// Expected columns are queued as rows are streamed and popped when the DUT presents a new column.
module tb_conv_line_buffer;

  localparam int BD = 8;
  localparam int W  = 4;
  localparam int H  = 5;

  logic          clk = 1'b0;
  logic          rst, start, pix_valid, pix_ready, shift_buffer;
  logic [BD-1:0] pix_in, in_l1, in_l2, in_l3;
  logic          lines_valid, busy, frame_done;
  logic [1:0]    col_idx;

  int          checks = 0;
  int          errors = 0;
  int          band_rises = 0;
  logic [31:0] exp_q [$];
  logic        lv_prev = 1'b0;
  logic        sh_prev = 1'b0;

  always #5 clk = ~clk;

  conv_line_buffer #(.BIT_DEPTH(BD), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .shift_buffer(shift_buffer), .in_l1(in_l1), .in_l2(in_l2),
    .in_l3(in_l3), .lines_valid(lines_valid), .col_idx(col_idx), .busy(busy),
    .frame_done(frame_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] px(input int r, input int c);
    return 8'(16 * r + c);
  endfunction

  task automatic push_band(input int b);
    for (int c = 0; c < W; c++) exp_q.push_back({px(b, c), px(b + 1, c), px(b + 2, c), 8'(c)});
  endtask

  // A new column is due when lines_valid rises or when an accepted shift preceded this cycle.
  always @(negedge clk) begin
    if (rst) begin
      lv_prev = 1'b0;
      sh_prev = 1'b0;
    end else begin
      if (lines_valid && (!lv_prev || sh_prev)) begin
        if (!lv_prev) band_rises++;
        if (exp_q.size() == 0) check_eq("unexpected_column", 32'd1, 32'd0);
        else check_eq("column", {in_l1, in_l2, in_l3, 6'b0, col_idx}, exp_q.pop_front());
      end
      lv_prev = lines_valid;
      sh_prev = shift_buffer & lines_valid;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
    check_eq({tag, "_lines_valid"}, 32'(lines_valid), 32'd0);
    check_eq({tag, "_lines"}, {8'd0, in_l1, in_l2, in_l3}, 32'd0);
    check_eq({tag, "_col_idx"}, 32'(col_idx), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  // Gap cycles also toggle start and shift_buffer, both of which must be ignored mid-fill.
  task automatic feed_px(input logic [7:0] v, input int gap);
    int waited = 0;
    pix_in    = v;
    pix_valid = 1'b1;
    while (!pix_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) check_eq("pix_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_in    = 8'hEE;
    repeat (gap) begin
      shift_buffer = 1'b1;
      start        = 1'b1;
      @(posedge clk); #1;
    end
    shift_buffer = 1'b0;
    start        = 1'b0;
  endtask

  task automatic feed_row(input int r, input int gap);
    for (int c = 0; c < W; c++) feed_px(px(r, c), (c == W - 1) ? 0 : gap);
  endtask

  task automatic shift_pulse();
    shift_buffer = 1'b1;
    @(posedge clk); #1;
    shift_buffer = 1'b0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_pix_ready", 32'(pix_ready), 32'd1);
  endtask

  task automatic serve_band(input int b, input bit hold);
    if (hold) begin
      shift_buffer = 1'b1;
      repeat (W - 1) @(posedge clk);
      #1;
      shift_buffer = 1'b0;
    end else begin
      repeat (W - 1) shift_pulse();
    end
    check_eq("last_col_idx", 32'(col_idx), W - 1);
    shift_pulse();
    check_eq("band_end_lines_valid", 32'(lines_valid), 32'd0);
    if (b < H - 3) begin
      check_eq("refill_pix_ready", 32'(pix_ready), 32'd1);
    end else begin
      check_eq("frame_done_pulse", 32'(frame_done), 32'd1);
      @(posedge clk); #1;
      check_eq("frame_done_clear", 32'(frame_done), 32'd0);
      check_eq("busy_after_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic run_frame(input int gap, input bit hold);
    band_rises = 0;
    start_frame();
    for (int r = 0; r < 3; r++) feed_row(r, gap);
    push_band(0);
    check_eq("first_col_latency", 32'(lines_valid), 32'd1);
    for (int b = 0; b < H - 2; b++) begin
      serve_band(b, hold);
      if (b < H - 3) begin
        feed_row(b + 3, gap);
        push_band(b + 1);
        check_eq("refill_col_latency", 32'(lines_valid), 32'd1);
      end
    end
    check_eq("bands_per_frame", 32'(band_rises), H - 2);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    pix_valid    = 1'b1;
    pix_in       = 8'hAA;
    shift_buffer = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst       = 1'b0;
    pix_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_busy", 32'(busy), 32'd0);

    run_frame(0, 1'b0);
    run_frame(2, 1'b1);

    start_frame();
    for (int r = 0; r < 3; r++) feed_row(r, 0);
    push_band(0);
    repeat (W) shift_pulse();
    check_eq("pre_abort_pix_ready", 32'(pix_ready), 32'd1);
    feed_px(px(3, 0), 0);
    feed_px(px(3, 1), 0);
    rst       = 1'b1;
    pix_valid = 1'b1;
    pix_in    = px(3, 2);
    @(posedge clk); #1;
    check_reset_outputs("abort");
    check_eq("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst       = 1'b0;
    pix_valid = 1'b0;
    @(posedge clk); #1;
    run_frame(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
